// File: rtl/vga_frame_ctrl.sv
// VGA frame timing controller: pixel-clock divider, h/v counters, line/frame strobes
// and a vblank-only update arbiter. Define VGA_FRAME_COUNTER_EN to build the frame counter.
module vga_frame_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525,
   parameter int VD      = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        pix_tick,
   output logic [9:0]  h_count,
   output logic [9:0]  v_count,
   output logic        line_start,
   output logic        frame_start,
   input  logic        upd_req,
   input  logic        upd_done,
   output logic        upd_grant,
   output logic        upd_overrun,
   output logic [15:0] frame_cnt
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_BLANK = 10'(VD);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_VB = 2'd1;
   localparam logic [1:0] ST_GRANT   = 2'd2;

   logic [DW-1:0] div_cnt;
   logic [1:0]    state;
   logic          div_wrap;
   logic          line_wrap;
   logic          frame_wrap;

   assign div_wrap   = en && (div_cnt == DIV_MAX);
   assign line_wrap  = div_wrap && (h_count == H_MAX);
   assign frame_wrap = line_wrap && (v_count == V_MAX);

   // Strobes are registered on the same edge that loads the wrapped counter values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         pix_tick    <= 1'b0;
         h_count     <= '0;
         v_count     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_tick    <= div_wrap;
         line_start  <= line_wrap;
         frame_start <= frame_wrap;
         if (en) begin
            if (div_wrap) div_cnt <= '0;
            else          div_cnt <= div_cnt + 1'b1;
         end
         if (div_wrap) begin
            if (line_wrap) begin
               h_count <= '0;
               if (frame_wrap) v_count <= '0;
               else            v_count <= v_count + 10'd1;
            end else begin
               h_count <= h_count + 10'd1;
            end
         end
      end
   end

   // Arbiter runs regardless of en so game logic is never stalled by a paused scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         upd_grant   <= 1'b0;
         upd_overrun <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               upd_grant <= 1'b0;
               if (upd_req) state <= ST_WAIT_VB;
            end
            ST_WAIT_VB: begin
               if (!upd_req) begin
                  state <= ST_IDLE;
               end else if (v_count >= V_BLANK) begin
                  state     <= ST_GRANT;
                  upd_grant <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (upd_done) begin
                  state     <= ST_IDLE;
                  upd_grant <= 1'b0;
               end else if (frame_start) begin
                  state       <= ST_IDLE;
                  upd_grant   <= 1'b0;
                  upd_overrun <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               upd_grant <= 1'b0;
            end
         endcase
      end
   end

`ifdef VGA_FRAME_COUNTER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          frame_cnt <= '0;
      else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
   end
`else
   assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Self-checking bench for vga_frame_ctrl: arithmetic scan model plus directed literal checks,
// run with a shrunken frame so several complete frames fit in a short simulation.
module tb_vga_frame_ctrl;

   localparam int TB_DIV = 4;
   localparam int TB_H   = 32;
   localparam int TB_V   = 16;
   localparam int TB_VD  = 12;
   localparam int FRAME_CLKS = TB_DIV * TB_H * TB_V;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b1;
   logic        upd_req = 1'b0;
   logic        upd_done = 1'b0;
   logic        pix_tick;
   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic        line_start;
   logic        frame_start;
   logic        upd_grant;
   logic        upd_overrun;
   logic [15:0] frame_cnt;

   int checks = 0;
   int passes = 0;

   // Model state: derived from the number of enabled clocks since reset.
   int m_en_clks = 0;
   int m_tick = 0, m_h = 0, m_v = 0, m_ls = 0, m_fs = 0, m_fc = 0;
   int m_grant = 0, m_ovr = 0, m_waiting = 0;

   vga_frame_ctrl #(
      .CLK_DIV(TB_DIV), .H_TOTAL(TB_H), .V_TOTAL(TB_V), .VD(TB_VD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .pix_tick(pix_tick), .h_count(h_count), .v_count(v_count),
      .line_start(line_start), .frame_start(frame_start),
      .upd_req(upd_req), .upd_done(upd_done),
      .upd_grant(upd_grant), .upd_overrun(upd_overrun),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // The arbiter part of the model sees the pre-edge scan position, like any registered consumer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en_clks = 0;
         m_tick = 0; m_h = 0; m_v = 0; m_ls = 0; m_fs = 0; m_fc = 0;
         m_grant = 0; m_ovr = 0; m_waiting = 0;
      end else begin
         if (m_grant != 0) begin
            if (upd_done) m_grant = 0;
            else if (m_fs != 0) begin
               m_grant = 0;
               m_ovr = 1;
            end
         end else if (m_waiting != 0) begin
            if (!upd_req) m_waiting = 0;
            else if (m_v >= TB_VD) begin
               m_waiting = 0;
               m_grant = 1;
            end
         end else if (upd_req) begin
            m_waiting = 1;
         end

         m_tick = 0; m_ls = 0; m_fs = 0;
         if (en) begin
            m_en_clks++;
            if (m_en_clks % TB_DIV == 0) begin
               int pix;
               pix = m_en_clks / TB_DIV;
               m_tick = 1;
               m_h = pix % TB_H;
               m_v = (pix / TB_H) % TB_V;
               m_ls = (m_h == 0) ? 1 : 0;
               m_fs = (m_h == 0 && m_v == 0) ? 1 : 0;
`ifdef VGA_FRAME_COUNTER_EN
               m_fc = (pix / (TB_H * TB_V)) % 65536;
`else
               m_fc = 0;
`endif
            end
         end
      end
   end

   bit compare_on = 1'b0;

   always @(negedge clk) begin
      if (compare_on && rst_n) begin
         checkOutput("cyc_pix_tick", int'(pix_tick), m_tick);
         checkOutput("cyc_h_count", int'(h_count), m_h);
         checkOutput("cyc_v_count", int'(v_count), m_v);
         checkOutput("cyc_line_start", int'(line_start), m_ls);
         checkOutput("cyc_frame_start", int'(frame_start), m_fs);
         checkOutput("cyc_upd_grant", int'(upd_grant), m_grant);
         checkOutput("cyc_upd_overrun", int'(upd_overrun), m_ovr);
         checkOutput("cyc_frame_cnt", int'(frame_cnt), m_fc);
      end
   end

   task automatic applyStimulus(input bit req, input bit done, input bit run);
      @(negedge clk);
      upd_req  = req;
      upd_done = done;
      en       = run;
   endtask

   task automatic waitFrameStart(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (m_fs != 0) return;
      end
      checkOutput("timeout_frame_start", 0, 1);
   endtask

   task automatic waitGrant(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (m_grant != 0) return;
      end
      checkOutput("timeout_grant", 0, 1);
   endtask

   initial begin
      int hold_h;
      int hold_v;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_pix_tick", int'(pix_tick), 0);
      checkOutput("rst_h_count", int'(h_count), 0);
      checkOutput("rst_v_count", int'(v_count), 0);
      checkOutput("rst_upd_grant", int'(upd_grant), 0);
      checkOutput("rst_frame_cnt", int'(frame_cnt), 0);
      rst_n = 1'b1;
      compare_on = 1'b1;

      // First tick on the 4th clock, then strict 4-clock spacing.
      repeat (4) @(posedge clk);
      #1;
      checkOutput("first_tick", int'(pix_tick), 1);
      checkOutput("first_tick_h", int'(h_count), 1);
      checkOutput("first_tick_ls", int'(line_start), 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("no_tick_clk7", int'(pix_tick), 0);
      @(posedge clk);
      #1;
      checkOutput("second_tick", int'(pix_tick), 1);
      checkOutput("second_tick_h", int'(h_count), 2);

      repeat (TB_DIV * TB_H - 8) @(posedge clk);
      #1;
      checkOutput("line_wrap_h", int'(h_count), 0);
      checkOutput("line_wrap_v", int'(v_count), 1);
      checkOutput("line_wrap_ls", int'(line_start), 1);
      checkOutput("line_wrap_fs", int'(frame_start), 0);
      @(posedge clk);
      #1;
      checkOutput("line_start_one_clk", int'(line_start), 0);

      repeat (FRAME_CLKS - TB_DIV * TB_H - 1) @(posedge clk);
      #1;
      checkOutput("frame_wrap_h", int'(h_count), 0);
      checkOutput("frame_wrap_v", int'(v_count), 0);
      checkOutput("frame_wrap_fs", int'(frame_start), 1);
      checkOutput("frame_wrap_ls", int'(line_start), 1);
`ifdef VGA_FRAME_COUNTER_EN
      checkOutput("frame_cnt_one", int'(frame_cnt), 1);
`else
      checkOutput("frame_cnt_tied", int'(frame_cnt), 0);
`endif

      // Request early in the frame: grant only once vblank is seen.
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (TB_DIV * TB_H * TB_VD) @(posedge clk);
      #1;
      checkOutput("vblank_entry_v", int'(v_count), TB_VD);
      checkOutput("grant_not_yet", int'(upd_grant), 0);
      @(posedge clk);
      #1;
      checkOutput("grant_rises", int'(upd_grant), 1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("grant_drops_on_done", int'(upd_grant), 0);
      checkOutput("no_overrun_on_done", int'(upd_overrun), 0);
      applyStimulus(1'b0, 1'b0, 1'b1);

      // Grant held open across frame start produces a sticky overrun.
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("regrant_in_vblank", int'(upd_grant), 1);
      waitFrameStart(FRAME_CLKS + 8);
      checkOutput("grant_open_at_fs", int'(upd_grant), 1);
      @(posedge clk);
      #1;
      checkOutput("grant_closed_after_fs", int'(upd_grant), 0);
      checkOutput("overrun_set", int'(upd_overrun), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);

      applyStimulus(1'b1, 1'b0, 1'b1);
      waitGrant(FRAME_CLKS + 8);
      applyStimulus(1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("clean_grant_done", int'(upd_grant), 0);
      checkOutput("overrun_sticky", int'(upd_overrun), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);

      // Pause mid-line: counters frozen, then resume.
      repeat (6) @(negedge clk);
      en = 1'b0;
      hold_h = m_h;
      hold_v = m_v;
      repeat (50) @(negedge clk);
      checkOutput("freeze_h", int'(h_count), hold_h);
      checkOutput("freeze_v", int'(v_count), hold_v);
      checkOutput("freeze_no_tick", int'(pix_tick), 0);
      en = 1'b1;
      repeat (20) @(negedge clk);

      // Reset during an open grant clears everything immediately.
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitGrant(FRAME_CLKS + 8);
      checkOutput("grant_before_reset", int'(upd_grant), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_grant", int'(upd_grant), 0);
      checkOutput("async_rst_overrun", int'(upd_overrun), 0);
      checkOutput("async_rst_h", int'(h_count), 0);
      checkOutput("async_rst_v", int'(v_count), 0);
      checkOutput("async_rst_tick", int'(pix_tick), 0);
      checkOutput("async_rst_frame_cnt", int'(frame_cnt), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vga_frame_ctrl.md
Name: vga_frame_ctrl

Overview:
- Timing controller for the VGA sync decoder.
- Divides the system clock into a pixel tick and runs the horizontal and vertical pixel counters that feed the sync decoder.
- Emits line/frame start strobes.
- Arbitrates game-state updates (laser, targets, score) so they are granted only during vertical blanking, never mid-scan.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
- H_TOTAL, 800, pixels per line including porches and retrace
- V_TOTAL, 525, lines per frame including porches and retrace
- VD, 480, visible lines; vertical blanking is v_count >= VD

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low freezes divider and counters
- pix_tick  out  1  one-clk pulse per pixel
- h_count  out  10  current pixel column, 0..H_TOTAL-1
- v_count  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when h_count becomes 0
- frame_start  out  1  one-clk pulse when h_count and v_count both become 0
- upd_req  in  1  game logic requests update window (level)
- upd_done  in  1  game logic finished update (one-clk pulse)
- upd_grant  out  1  update permitted
- upd_overrun  out  1  sticky: a grant was still open at frame start
- frame_cnt  out  16  frames completed (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): divider=0, h_count=0, v_count=0, pix_tick=0, line_start=0, frame_start=0, upd_grant=0, upd_overrun=0, frame_cnt=0, FSM=IDLE.
- All outputs are registered.
- Divider:
  - Counts 0..CLK_DIV-1 while en=1.
  - pix_tick=1 for the clk after the divider reaches CLK_DIV-1; the divider wraps to 0.
  - en=0: divider holds, pix_tick=0.
- Counters advance only on the clk where the divider wraps (same edge pix_tick is registered):
  - h_count += 1; at H_TOTAL-1 it wraps to 0 and v_count += 1.
  - v_count wraps to 0 when both counters are at their maximum.
  - No other values are reachable.
- line_start and frame_start are asserted in the same cycle the new count values first appear.
  - frame_start implies line_start.
  - Neither pulse is asserted at reset release.
- Arbiter FSM, evaluated every clk regardless of en:
  - IDLE: upd_req=1 -> WAIT_VB.
  - WAIT_VB: v_count >= VD -> GRANT, with upd_grant=1 from the next cycle. upd_req dropping -> IDLE.
  - GRANT: upd_grant=1.
    - upd_done=1 -> IDLE, grant low next cycle.
    - frame_start=1 and upd_done=0 -> IDLE, grant low next cycle, upd_overrun set.
    - upd_done and frame_start in the same cycle count as done: no overrun.
  - upd_req held high after done: IDLE -> WAIT_VB -> GRANT re-grants within the same blanking window if still in vblank. Minimum 2 cycles between grants.
- upd_overrun clears only on reset.
- Reset asserted mid-grant: grant drops immediately (async); no overrun recorded.
- upd_done outside GRANT: ignored.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- Defined: frame_cnt increments by 1 on each frame_start and wraps 65535 -> 0.
- Undefined: no counter logic is built; frame_cnt is tied to 0.

Test Plan:
- Reset release, en=1, CLK_DIV=4 -> first pix_tick at clk 4; h_count=1 on that cycle; pix_tick period exactly 4 clks.
- Run to h_count=799 -> next tick gives h_count=0, v_count+1, line_start=1 for one clk; frame_start=0 unless v wrapped.
- Run to h=799, v=524 -> next tick gives (0,0), frame_start=1, line_start=1; with the macro, frame_cnt 0 -> 1.
- upd_req=1 at v_count=100 -> upd_grant stays 0 until v_count=480, then rises 1 clk later; upd_done pulse -> grant low next clk, upd_overrun=0.
- Grant open, no upd_done through frame_start -> upd_grant low next clk, upd_overrun=1 and remains 1 through later successful grants until rst_n pulse.
- en=0 for 50 clks mid-line -> h_count/v_count frozen, no pix_tick; en=1 resumes from the same values, 4-clk spacing preserved; rst_n low mid-grant -> all outputs 0 asynchronously.
